// File: rtl/pc_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : pc_sequencer
//  Description : Next-PC controller for the MIPS fetch stage. Holds the PC,
//                issues fetches under a req/ready handshake and applies
//                captured branch / jump / register-jump redirects.
//                Optional feature macro: PC_DELAY_SLOT_EN (MIPS delay slot;
//                when undefined, flush marks the wrong-path instruction).
//  Revision    : 1.0 - initial release
// ============================================================================
module pc_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        imem_ready,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [15:0] branch_imm,
    input  logic        jump,
    input  logic [25:0] jump_target,
    input  logic        jr,
    input  logic [31:0] jr_addr,
    output logic        imem_req,
    output logic [31:0] pc,
    output logic [31:0] pc_id,
    output logic        flush,
    output logic        misaligned
);

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2
    } state_t;

    localparam logic [31:0] C_BOOT_PC = {RESET_PC[31:2], 2'b00};

    state_t      r_state;
    state_t      w_state_nxt;
    logic        r_pend_valid;
    logic [31:0] r_pend_target;
    logic        w_complete;
    logic        w_capture;
    logic        w_apply;
    logic [31:0] w_seq;
    logic [31:0] w_br_off;
    logic [31:0] w_target;
    logic [31:0] w_pc_nxt;

    assign w_complete = imem_req & imem_ready;
    assign w_capture  = jr | jump | branch_taken;

    // Redirect targets are all relative to the instruction in decode (pc_id)
    assign w_seq    = pc_id + 32'd4;
    assign w_br_off = {{14{branch_imm[15]}}, branch_imm, 2'b00};

    // Target mux: jr beats jump beats branch; misaligned jr is word-aligned
    always_comb begin
        w_target = w_seq + w_br_off;
        if (jr) begin
            w_target = {jr_addr[31:2], 2'b00};
        end else if (jump) begin
            w_target = {w_seq[31:28], jump_target, 2'b00};
        end
    end

`ifdef PC_DELAY_SLOT_EN
    // Set when the delay-slot instruction (the fetch in flight at capture)
    // has not yet completed, so the target must wait one more completion.
    logic r_pend_wait;

    // Track whether the delay slot still has to complete
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pend_wait <= 1'b0;
        end else if (w_capture) begin
            r_pend_wait <= ~w_complete;
        end else if (w_complete) begin
            r_pend_wait <= 1'b0;
        end
    end

    assign w_apply = w_complete & r_pend_valid & ~r_pend_wait;
    assign flush   = 1'b0;
`else
    assign w_apply = w_complete & r_pend_valid;
    assign flush   = w_apply;
`endif

    assign w_pc_nxt = w_apply ? r_pend_target : (pc + 32'd4);

    // FSM next state and fetch request
    always_comb begin
        w_state_nxt = r_state;
        imem_req    = 1'b0;
        case (r_state)
            BOOT: begin
                w_state_nxt = FETCH;
            end
            FETCH: begin
                imem_req = 1'b1;
                if (imem_ready && stall) begin
                    w_state_nxt = HOLD;
                end
            end
            HOLD: begin
                if (!stall) begin
                    w_state_nxt = FETCH;
                end
            end
            default: begin
                w_state_nxt = BOOT;
            end
        endcase
    end

    // FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= BOOT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // PC and decode PC advance only on a completed fetch
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc    <= C_BOOT_PC;
            pc_id <= C_BOOT_PC;
        end else if (w_complete) begin
            pc    <= w_pc_nxt;
            pc_id <= pc;
        end
    end

    // Pending redirect: a new pulse overwrites, an application consumes it
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pend_valid  <= 1'b0;
            r_pend_target <= 32'd0;
        end else if (w_capture) begin
            r_pend_valid  <= 1'b1;
            r_pend_target <= w_target;
        end else if (w_apply) begin
            r_pend_valid  <= 1'b0;
        end
    end

    // Sticky flag for a captured jr to a non-word-aligned address
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            misaligned <= 1'b0;
        end else if (jr && (jr_addr[1:0] != 2'b00)) begin
            misaligned <= 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pc_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pc_sequencer
//  Description : Self-checking bench for pc_sequencer. A scoreboard holds the
//                expected fetch address of every completed fetch; scenario
//                tasks check the remaining outputs inline.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pc_sequencer;

    logic        clk;
    logic        reset;
    logic        imem_ready;
    logic        stall;
    logic        branch_taken;
    logic [15:0] branch_imm;
    logic        jump;
    logic [25:0] jump_target;
    logic        jr;
    logic [31:0] jr_addr;
    logic        imem_req;
    logic [31:0] pc;
    logic [31:0] pc_id;
    logic        flush;
    logic        misaligned;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];

    pc_sequencer #(.RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .reset(reset), .imem_ready(imem_ready), .stall(stall),
        .branch_taken(branch_taken), .branch_imm(branch_imm), .jump(jump),
        .jump_target(jump_target), .jr(jr), .jr_addr(jr_addr),
        .imem_req(imem_req), .pc(pc), .pc_id(pc_id), .flush(flush),
        .misaligned(misaligned)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard: every completed fetch must match the next expected address
    always @(negedge clk) begin
        if (!reset && imem_req && imem_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected_fetch pc=%h expected none", pc);
            end else begin
                logic [31:0] e;
                e = exp_q.pop_front();
                if (pc !== e) begin
                    errors++;
                    $display("FAIL sb_fetch_pc got %h expected %h", pc, e);
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; imem_ready = 1'b1; stall = 1'b0;
        branch_taken = 1'b0; branch_imm = 16'h0; jump = 1'b0;
        jump_target = 26'h0; jr = 1'b0; jr_addr = 32'h0;
        tick(2);
        checks++;
        if (imem_req !== 1'b0 || pc !== 32'h0 || pc_id !== 32'h0 || flush !== 1'b0 || misaligned !== 1'b0) begin
            errors++;
            $display("FAIL reset_values got req=%b pc=%h pc_id=%h flush=%b mis=%b expected 0/0/0/0/0", imem_req, pc, pc_id, flush, misaligned);
        end
        reset = 1'b0;
        checks++;
        if (imem_req !== 1'b0) begin errors++; $display("FAIL boot_req got %b expected 0", imem_req); end
        exp_q.push_back(32'h0); exp_q.push_back(32'h4);
        exp_q.push_back(32'h8); exp_q.push_back(32'hC);
        tick(1);
        checks++;
        if (imem_req !== 1'b1) begin errors++; $display("FAIL first_req got %b expected 1", imem_req); end
        for (int i = 1; i <= 4; i++) begin
            tick(1);
            checks++;
            if (pc !== 32'(i * 4) || pc_id !== 32'((i - 1) * 4)) begin
                errors++;
                $display("FAIL seq_step%0d got pc=%h pc_id=%h expected %h/%h", i, pc, pc_id, 32'(i * 4), 32'((i - 1) * 4));
            end
        end
        imem_ready = 1'b0;
    endtask

    task automatic test_branch();
        imem_ready = 1'b1;
        for (int a = 'h10; a <= 'h40; a += 4) exp_q.push_back(32'(a));
        tick(13);
        checks++;
        if (pc !== 32'h44 || pc_id !== 32'h40) begin
            errors++; $display("FAIL br_setup got pc=%h pc_id=%h expected 44/40", pc, pc_id);
        end
        branch_taken = 1'b1; branch_imm = 16'hFFFE;
        exp_q.push_back(32'h44); exp_q.push_back(32'h48);
        #1;
        checks++;
        if (flush !== 1'b0) begin errors++; $display("FAIL br_flush_early got %b expected 0", flush); end
        tick(1);
        branch_taken = 1'b0;
        checks++;
`ifdef PC_DELAY_SLOT_EN
        if (flush !== 1'b0) begin errors++; $display("FAIL br_flush got %b expected 0", flush); end
`else
        if (flush !== 1'b1) begin errors++; $display("FAIL br_flush got %b expected 1", flush); end
`endif
        tick(1);
        imem_ready = 1'b0;
        checks++;
        if (pc !== 32'h3C || flush !== 1'b0) begin
            errors++; $display("FAIL br_target got pc=%h flush=%b expected 3c/0", pc, flush);
        end
    endtask

    task automatic test_jump();
        imem_ready = 1'b1; jr = 1'b1; jr_addr = 32'hA000_0010;
        exp_q.push_back(32'h3C);
        tick(1);
        jr = 1'b0;
        exp_q.push_back(32'h40);
        checks++;
        if (pc !== 32'h40) begin errors++; $display("FAIL jr_seq got %h expected 40", pc); end
        tick(1);
        exp_q.push_back(32'hA000_0010);
        checks++;
        if (pc !== 32'hA000_0010) begin errors++; $display("FAIL jr_target got %h expected a0000010", pc); end
        tick(1);
        checks++;
        if (pc_id !== 32'hA000_0010) begin errors++; $display("FAIL jmp_pc_id got %h expected a0000010", pc_id); end
        jump = 1'b1; jump_target = 26'h0000100;
        exp_q.push_back(32'hA000_0014);
        tick(1);
        jump = 1'b0;
        exp_q.push_back(32'hA000_0018);
        tick(1);
        imem_ready = 1'b0;
        checks++;
        if (pc !== 32'hA000_0400 || misaligned !== 1'b0) begin
            errors++; $display("FAIL jmp_target got pc=%h mis=%b expected a0000400/0", pc, misaligned);
        end
    endtask

    task automatic test_priority();
        imem_ready = 1'b1;
        jr = 1'b1; jr_addr = 32'h0000_1002;
        jump = 1'b1; jump_target = 26'h3FF_FFFF;
        branch_taken = 1'b1; branch_imm = 16'h7FFF;
        exp_q.push_back(32'hA000_0400);
        tick(1);
        jr = 1'b0; jump = 1'b0; branch_taken = 1'b0;
        exp_q.push_back(32'hA000_0404);
        tick(1);
        imem_ready = 1'b0;
        checks++;
        if (pc !== 32'h1000 || misaligned !== 1'b1) begin
            errors++; $display("FAIL prio_jr got pc=%h mis=%b expected 1000/1", pc, misaligned);
        end
    endtask

    task automatic test_ready_stall();
        logic [31:0] held;
        stall = 1'b1; branch_taken = 1'b1; branch_imm = 16'h0010;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (imem_req !== 1'b1 || pc !== 32'h1000) begin
                errors++; $display("FAIL wait_stable%0d got req=%b pc=%h expected 1/1000", i, imem_req, pc);
            end
            tick(1);
            branch_taken = 1'b0;
            stall = (i == 0) ? 1'b0 : 1'b1;
        end
        imem_ready = 1'b1; stall = 1'b1;
        exp_q.push_back(32'h1000);
        #1;
        checks++;
`ifdef PC_DELAY_SLOT_EN
        held = 32'h1004;
        if (flush !== 1'b0) begin errors++; $display("FAIL rs_flush got %b expected 0", flush); end
`else
        held = 32'hA000_0448;
        if (flush !== 1'b1) begin errors++; $display("FAIL rs_flush got %b expected 1", flush); end
`endif
        for (int i = 0; i < 2; i++) begin
            tick(1);
            checks++;
            if (imem_req !== 1'b0 || pc !== held || pc_id !== 32'h1000) begin
                errors++; $display("FAIL hold%0d got req=%b pc=%h pc_id=%h expected 0/%h/1000", i, imem_req, pc, pc_id, held);
            end
        end
        stall = 1'b0;
        tick(1);
        exp_q.push_back(held);
        checks++;
        if (imem_req !== 1'b1) begin errors++; $display("FAIL hold_exit got %b expected 1", imem_req); end
        tick(1);
        imem_ready = 1'b0;
        checks++;
`ifdef PC_DELAY_SLOT_EN
        if (pc !== 32'hA000_0448 || misaligned !== 1'b1) begin
            errors++; $display("FAIL rs_after got pc=%h mis=%b expected a0000448/1", pc, misaligned);
        end
`else
        if (pc !== 32'hA000_044C || misaligned !== 1'b1) begin
            errors++; $display("FAIL rs_after got pc=%h mis=%b expected a000044c/1", pc, misaligned);
        end
`endif
    endtask

    task automatic test_reset_pending();
        jr = 1'b1; jr_addr = 32'h0000_2000;
        tick(1);
        jr = 1'b0;
        reset = 1'b1;
        #1;
        checks++;
        if (imem_req !== 1'b0 || pc !== 32'h0 || pc_id !== 32'h0 || misaligned !== 1'b0 || flush !== 1'b0) begin
            errors++;
            $display("FAIL async_reset got req=%b pc=%h pc_id=%h mis=%b flush=%b expected 0/0/0/0/0", imem_req, pc, pc_id, misaligned, flush);
        end
        tick(1);
        reset = 1'b0; imem_ready = 1'b1;
        exp_q.push_back(32'h0); exp_q.push_back(32'h4); exp_q.push_back(32'h8);
        tick(4);
        imem_ready = 1'b0;
        checks++;
        if (pc !== 32'hC || pc_id !== 32'h8 || misaligned !== 1'b0) begin
            errors++; $display("FAIL restart got pc=%h pc_id=%h mis=%b expected c/8/0", pc, pc_id, misaligned);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_branch();
        test_jump();
        test_priority();
        test_ready_stall();
        test_reset_pending();
        tick(2);
        checks++;
        if (exp_q.size() != 0) begin
            errors++; $display("FAIL sb_leftover got %0d expected 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
